// File: rtl/acumulador_produtos_if.sv
// Product-stream / result handshake bundle for acumulador_produtos.
// master drives products and S_ready; slave is the accumulator.
interface acumulador_produtos_if #(
    parameter int TAM   = 8,
    parameter int GUARD = 4
);
    localparam int W = 2 * TAM + GUARD;

    logic [2*TAM-1:0] P;
    logic             P_valid;
    logic             P_ready;
    logic [W-1:0]     S_acc;
    logic             S_valid;
    logic             S_ready;

    modport master (
        output P, P_valid, S_ready,
        input  P_ready, S_acc, S_valid
    );

    modport slave (
        input  P, P_valid, S_ready,
        output P_ready, S_acc, S_valid
    );
endinterface

// File: rtl/acumulador_produtos.sv
// Sums LEN accepted products into one wide result and presents it with
// a valid/ready handshake, back-pressuring the product stream meanwhile.
module acumulador_produtos #(
    parameter int TAM   = 8,
    parameter int LEN   = 4,
    parameter int GUARD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    acumulador_produtos_if.slave bus
);
    localparam int W  = 2 * TAM + GUARD;
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {ACUM, SAIDA} state_t;

    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_s_acc;
    logic            r_s_valid;

    logic [W-1:0]    w_p_ext;
    logic [W-1:0]    w_sum;
    logic            w_accept;
    logic            w_p_ready;

    assign w_p_ext   = {{GUARD{1'b0}}, bus.P};
    assign w_sum     = r_acc + w_p_ext;
    assign w_p_ready = (r_state == ACUM) && !rst;
    assign w_accept  = bus.P_valid && w_p_ready;

    assign bus.P_ready = w_p_ready;
    assign bus.S_acc   = r_s_acc;
    assign bus.S_valid = r_s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_s_acc   <= '0;
            r_s_valid <= 1'b0;
        end else if (clr) begin
            // S_acc deliberately kept; it is don't-care while S_valid=0
            r_state   <= ACUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_s_valid <= 1'b0;
        end else begin
            case (r_state)
                ACUM: begin
                    if (w_accept) begin
                        if (r_cnt == LAST) begin
                            r_s_acc   <= w_sum;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_s_valid <= 1'b1;
                            r_state   <= SAIDA;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                SAIDA: begin
                    if (bus.S_ready) begin
                        r_s_valid <= 1'b0;
                        r_state   <= ACUM;
                    end
                end
                default: r_state <= ACUM;
            endcase
        end
    end
endmodule
